// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  // Loader progress through one program image.
  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CSUM,
    HOLD,
    RUN,
    ERR
  } ldr_state_t;

  // Bytes per instruction word and bytes in the length header.
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_LEN        = 2;

  // States in which the byte stream is being consumed.
  function automatic logic state_takes_bytes(input ldr_state_t s);
    return (s == HDR0) || (s == HDR1) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction-memory loader.
interface imem_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  // The producer of the program stream.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  // The loader consuming the program stream.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects four accepted bytes into one little-endian 32-bit word.
// The fourth byte is passed straight through so the word is available
// on the same cycle that byte is accepted.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0] r_idx;
  logic [7:0] r_b0;
  logic [7:0] r_b1;
  logic [7:0] r_b2;

  // Track the byte position and capture the first three bytes of a word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= 2'd0;
      r_b0  <= 8'd0;
      r_b1  <= 8'd0;
      r_b2  <= 8'd0;
    end else if (i_clr) begin
      r_idx <= 2'd0;
    end else if (i_valid) begin
      case (r_idx)
        2'd0:    r_b0 <= i_byte;
        2'd1:    r_b1 <= i_byte;
        2'd2:    r_b2 <= i_byte;
        default: ;
      endcase
      r_idx <= r_idx + 2'd1;
    end
  end

  assign o_word_valid = i_valid && (r_idx == LAST_IDX);
  assign o_word       = {i_byte, r_b2, r_b1, r_b0};

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed, checksummed
// program over a byte stream, writes it into the instruction RAM, and
// keeps the core in reset until the image has verified. The same RAM
// serves the core's combinational fetch port, masked by the number of
// words written so far.
module imem_loader
  import loader_pkg::*;
#(
  parameter  int DEPTH         = 64,
  parameter  int RELEASE_DELAY = 4,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  imem_loader_if.slave   s_in,
  input  logic           reload,
  input  logic [31:0]    pc_addr,
  output logic [31:0]    instr,
  output logic           cpu_reset,
  output logic           load_done,
  output logic           load_err,
  output logic [AW:0]    word_count
);

  localparam logic [15:0] DEPTH_W   = 16'(DEPTH);
  localparam logic [7:0]  HOLD_INIT = 8'(RELEASE_DELAY);

  ldr_state_t  r_state;
  logic [15:0] r_count;
  logic [7:0]  r_acc;
  logic [7:0]  r_hold;
  logic        r_cpu_reset;
  logic        r_in_ready;
  logic        r_load_done;
  logic        r_load_err;
  logic [AW:0] r_word_count;

  logic [31:0] r_ram [DEPTH];

  logic        w_accept;
  logic        w_reload;
  logic        w_asm_valid;
  logic        w_word_valid;
  logic [31:0] w_word;
  logic [15:0] w_full_count;
  logic [AW:0] w_wc_inc;
  logic        w_count_bad;
  logic [AW-1:0] w_fetch_idx;
  logic        w_fetch_hit;
  logic        w_unused_pc_bits;

  assign w_accept     = s_in.in_valid && r_in_ready;
  assign w_reload     = reload && ((r_state == RUN) || (r_state == ERR));
  assign w_asm_valid  = w_accept && (r_state == DATA);
  assign w_full_count = {s_in.in_data, r_count[7:0]};
  assign w_wc_inc     = r_word_count + {{AW{1'b0}}, 1'b1};
  assign w_count_bad  = (w_full_count == 16'd0) || (w_full_count > DEPTH_W);

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_reload),
    .i_valid      (w_asm_valid),
    .i_byte       (s_in.in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Load sequencing; every output flag is a register updated with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= HDR0;
      r_count      <= 16'd0;
      r_acc        <= 8'd0;
      r_hold       <= 8'd0;
      r_cpu_reset  <= 1'b1;
      r_in_ready   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_word_count <= '0;
    end else if (w_reload) begin
      r_state      <= HDR0;
      r_acc        <= 8'd0;
      r_cpu_reset  <= 1'b1;
      r_in_ready   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        HDR0: begin
          if (w_accept) begin
            r_count <= {8'd0, s_in.in_data};
            r_state <= HDR1;
          end
        end
        HDR1: begin
          if (w_accept) begin
            r_count <= w_full_count;
            if (w_count_bad) begin
              r_state    <= ERR;
              r_in_ready <= 1'b0;
              r_load_err <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_accept) begin
            r_acc <= r_acc ^ s_in.in_data;
            if (w_word_valid) begin
              r_word_count <= w_wc_inc;
              // Last word of the image: the next byte is the checksum.
              if (16'(w_wc_inc) == r_count) begin
                r_state <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (s_in.in_data == r_acc) begin
              r_state <= HOLD;
              r_hold  <= HOLD_INIT;
            end else begin
              r_state    <= ERR;
              r_load_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Count down so the core leaves reset exactly RELEASE_DELAY
          // edges after the checksum byte was taken.
          if (r_hold <= 8'd1) begin
            r_state     <= RUN;
            r_cpu_reset <= 1'b0;
            r_load_done <= 1'b1;
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end
        RUN: ;
        ERR: ;
        default: begin
          r_state     <= HDR0;
          r_cpu_reset <= 1'b1;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Instruction RAM write port; contents survive reset and reload.
  always_ff @(posedge clk) begin
    if (w_word_valid) begin
      r_ram[r_word_count[AW-1:0]] <= w_word;
    end
  end

  // Fetch reads only words written by the current or last load.
  assign w_fetch_idx = pc_addr[AW+1:2];
  assign w_fetch_hit = ({1'b0, w_fetch_idx} < r_word_count);
  assign instr       = w_fetch_hit ? r_ram[w_fetch_idx] : 32'd0;

  assign w_unused_pc_bits = ^{pc_addr[31:AW+2], pc_addr[1:0]};

  assign s_in.in_ready = r_in_ready;
  assign cpu_reset     = r_cpu_reset;
  assign load_done     = r_load_done;
  assign load_err      = r_load_err;
  assign word_count    = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed scenarios plus randomized loads, checked
// every cycle against a stream-position model of the loader.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int RD    = 4;
  localparam int AW    = 6;

  localparam int PH_LOAD = 0;
  localparam int PH_HOLD = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_ERR  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          reload = 1'b0;
  logic [31:0]   pc_addr = 32'd0;
  logic [31:0]   instr;
  logic          cpu_reset;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH), .RELEASE_DELAY(RD)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_in       (bus),
    .reload     (reload),
    .pc_addr    (pc_addr),
    .instr      (instr),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit rand_reload_en = 1'b0;
  logic [7:0] stream[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model (by stream position) ----------------
  int          m_phase;
  int          m_pos;
  int          m_cnt;
  int          m_wc;
  int          m_hold;
  logic [7:0]  m_xor;
  logic [7:0]  m_b[4];
  logic [31:0] m_mem[DEPTH];

  task model_reset();
    m_phase = PH_LOAD;
    m_pos   = 0;
    m_cnt   = 0;
    m_wc    = 0;
    m_hold  = 0;
    m_xor   = 8'd0;
  endtask

  task model_byte(input logic [7:0] b);
    int k;
    if (m_pos == 0) begin
      m_cnt = int'(b);
    end else if (m_pos == 1) begin
      m_cnt = m_cnt + 256 * int'(b);
      if (m_cnt == 0 || m_cnt > DEPTH) m_phase = PH_ERR;
    end else if (m_pos < 2 + 4 * m_cnt) begin
      k = m_pos - 2;
      m_xor = m_xor ^ b;
      m_b[k % 4] = b;
      if (k % 4 == 3) begin
        m_mem[m_wc] = {m_b[3], m_b[2], m_b[1], m_b[0]};
        m_wc++;
      end
    end else begin
      m_phase = (b == m_xor) ? PH_HOLD : PH_ERR;
      m_hold  = RD;
    end
    m_pos++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else if (reload && (m_phase == PH_RUN || m_phase == PH_ERR)) model_reset();
      else if (m_phase == PH_HOLD) begin
        m_hold--;
        if (m_hold == 0) m_phase = PH_RUN;
      end else if (m_phase == PH_LOAD && bus.in_valid) model_byte(bus.in_data);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      idx = int'(pc_addr[AW+1:2]);
      chk("in_ready",   32'(bus.in_ready), 32'(m_phase == PH_LOAD));
      chk("cpu_reset",  32'(cpu_reset),    32'(m_phase != PH_RUN));
      chk("load_done",  32'(load_done),    32'(m_phase == PH_RUN));
      chk("load_err",   32'(load_err),     32'(m_phase == PH_ERR));
      chk("word_count", 32'(word_count),   32'(m_wc));
      chk("instr",      instr,             (idx < m_wc) ? m_mem[idx] : 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task tick();
    @(posedge clk);
    #1;
    pc_addr = $urandom;
    if (rand_reload_en) reload = ($urandom_range(0, 7) == 0);
  endtask

  task send_byte(input logic [7:0] b, input int stall);
    bit ok;
    bit done;
    done = 1'b0;
    repeat (stall) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 64 && !done; i++) begin
      ok = bus.in_ready;
      tick();
      if (ok) begin
        acc_cyc = cyc;
        done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // mode 0: random 0..2 stall before each byte; mode 1: exactly 3 stall
  // cycles spread inside every data word; mode 2: no stalls.
  task send_stream(input int mode);
    int st[4];
    int k;
    st = '{0, 0, 0, 0};
    for (int i = 0; i < stream.size(); i++) begin
      k = (i - 2) % 4;
      if (mode == 1 && i >= 2 && i < stream.size() - 1) begin
        if (k == 0) begin
          st[1] = $urandom_range(0, 3);
          st[2] = $urandom_range(0, 3 - st[1]);
          st[3] = 3 - st[1] - st[2];
        end
        send_byte(stream[i], st[k]);
      end else if (mode == 0) begin
        send_byte(stream[i], $urandom_range(0, 2));
      end else begin
        send_byte(stream[i], 0);
      end
    end
  endtask

  task build_stream(input int n, input bit bad);
    logic [7:0] x;
    logic [7:0] d;
    x = 8'd0;
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      d = 8'($urandom);
      x = x ^ d;
      stream.push_back(d);
    end
    stream.push_back(bad ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
  endtask

  task wait_release(input string name);
    int n;
    n = 0;
    while (cpu_reset === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(name, 32'(cyc - acc_cyc), 32'(RD));
  endtask

  task pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task fetch_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    pc_addr = addr;
    #1;
    chk(name, instr, exp);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (3) tick();
    chk("rst_cpu_reset",  32'(cpu_reset),    32'd1);
    chk("rst_in_ready",   32'(bus.in_ready), 32'd1);
    chk("rst_load_done",  32'(load_done),    32'd0);
    chk("rst_word_count", 32'(word_count),   32'd0);
    reset = 1'b0;
    tick();

    // Normal load.
    stream = '{8'h02, 8'h00, 8'h07, 8'h00, 8'hA0, 8'hE3, 8'h64, 8'h00, 8'h80, 8'hE5, 8'h45};
    send_stream(2);
    wait_release("normal_latency");
    chk("normal_done", 32'(load_done), 32'd1);
    chk("normal_wc", 32'(word_count), 32'd2);
    fetch_chk("fetch_0", 32'h0, 32'hE3A00007);
    fetch_chk("fetch_4", 32'h4, 32'hE5800064);
    fetch_chk("fetch_8", 32'h8, 32'h0);
    fetch_chk("fetch_hi_bits", 32'hF000_0107, 32'hE5800064);

    // Bad checksum.
    pulse_reload();
    chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reload_wc", 32'(word_count), 32'd0);
    stream[10] = 8'h44;
    send_stream(0);
    repeat (3) tick();
    chk("badcs_err", 32'(load_err), 32'd1);
    chk("badcs_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("badcs_ready", 32'(bus.in_ready), 32'd0);
    chk("badcs_done", 32'(load_done), 32'd0);

    // Oversize header.
    pulse_reload();
    stream = '{8'h41, 8'h00};
    send_stream(2);
    tick();
    chk("oversize_err", 32'(load_err), 32'd1);
    chk("oversize_wc", 32'(word_count), 32'd0);

    // Zero header.
    pulse_reload();
    stream = '{8'h00, 8'h00};
    send_stream(2);
    tick();
    chk("zero_err", 32'(load_err), 32'd1);
    chk("zero_wc", 32'(word_count), 32'd0);

    // High count byte alone pushes the length past DEPTH.
    pulse_reload();
    stream = '{8'h01, 8'h01};
    send_stream(2);
    tick();
    chk("hibyte_err", 32'(load_err), 32'd1);

    // Normal load with stalls inside every word.
    pulse_reload();
    stream = '{8'h02, 8'h00, 8'h07, 8'h00, 8'hA0, 8'hE3, 8'h64, 8'h00, 8'h80, 8'hE5, 8'h45};
    send_stream(1);
    wait_release("stall_latency");
    fetch_chk("stall_fetch_0", 32'h0, 32'hE3A00007);
    fetch_chk("stall_fetch_4", 32'h4, 32'hE5800064);

    // Reload from RUN and load a single word.
    pulse_reload();
    chk("reload_run_cpu_reset", 32'(cpu_reset), 32'd1);
    stream = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    send_stream(0);
    wait_release("one_word_latency");
    chk("one_word_wc", 32'(word_count), 32'd1);
    fetch_chk("one_word_fetch_0", 32'h0, 32'h00000001);
    fetch_chk("one_word_fetch_4", 32'h4, 32'h0);

    // Reset after five bytes of a second load.
    pulse_reload();
    build_stream(3, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(stream[i], 0);
    reset = 1'b1;
    #1;
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("midrst_wc", 32'(word_count), 32'd0);
    chk("midrst_ready", 32'(bus.in_ready), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Randomized loads, including a full-depth image and ignored reloads.
    for (int t = 0; t < 8; t++) begin
      int n;
      bit bad;
      if (load_done || load_err) pulse_reload();
      n   = (t == 0) ? DEPTH : $urandom_range(1, 24);
      bad = ($urandom_range(0, 3) == 0);
      build_stream(n, bad);
      rand_reload_en = 1'b1;
      send_stream(0);
      rand_reload_en = 1'b0;
      reload = 1'b0;
      if (!bad) wait_release("rand_latency");
      else repeat (3) tick();
      repeat (4) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
